// File: rtl/cnn_result_streamer.sv
// Streams the cnn_engine result feature map out of its synchronous-read RAM as a
// valid/ready stream, using a 2-entry prefetch FIFO to hide the 1-cycle read latency.
module cnn_result_streamer #(
  parameter int OUT_W  = 6,
  parameter int OUT_H  = 6,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              drained,
  output logic [1:0]        dbg_state
);

  localparam int N  = OUT_W * OUT_H;
  localparam int CW = ADDR_W + 1;

  // Stream handshake: a word moves when m_valid && m_ready at posedge; while
  // m_valid is high and m_ready low, m_data and m_last do not change.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_done_q;
  logic [CW-1:0]     r_issue_cnt;
  logic [CW-1:0]     r_out_cnt;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              r_inflight;

  logic              w_trigger;
  logic              w_pop;
  logic              w_last_xfer;
  logic [2:0]        w_credit;

  assign w_trigger   = (r_state == S_IDLE) && done_in && !r_done_q;
  assign m_valid     = (r_count != 2'd0);
  assign m_data      = r_buf[r_rd_ptr];
  assign m_last      = m_valid && (r_out_cnt == CW'(N - 1));
  assign w_pop       = m_valid && m_ready;
  assign w_last_xfer = w_pop && (r_out_cnt == CW'(N - 1));

  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what lets the stream run at one beat per cycle.
  assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign rd_en    = (r_state == S_STREAM) && (r_issue_cnt < CW'(N)) && (w_credit < 3'd2);
  assign rd_addr  = r_issue_cnt[ADDR_W-1:0];

  assign busy      = (r_state == S_STREAM);
  assign drained   = (r_state == S_FINISH);
  assign dbg_state = r_state;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_trigger) w_next_state = S_STREAM;
      S_STREAM: if (w_last_xfer) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_done_q    <= 1'b0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_inflight  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_done_q <= done_in;
      if (w_trigger) begin
        r_issue_cnt <= '0;
        r_out_cnt   <= '0;
        r_rd_ptr    <= 1'b0;
        r_wr_ptr    <= 1'b0;
        r_count     <= 2'd0;
        r_inflight  <= 1'b0;
      end else begin
        r_inflight <= rd_en;
        if (rd_en) r_issue_cnt <= r_issue_cnt + 1'b1;
        if (r_inflight) begin
          r_buf[r_wr_ptr] <= rd_data;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
          if (!w_last_xfer) r_out_cnt <= r_out_cnt + 1'b1;
        end
        case ({r_inflight, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_result_streamer.sv
// Bench for cnn_result_streamer: RAM stub, per-cycle stream monitor and
// scenario tasks comparing the stream with a queue built from RAM contents.
module tb_cnn_result_streamer;

  localparam int N = 36;

  logic        clk;
  logic        rst_n;
  logic        done_in;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        drained;
  logic [1:0]  dbg_state;

  cnn_result_streamer #(.OUT_W(6), .OUT_H(6), .DATA_W(32), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .drained(drained), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / RAM stub ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:63];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // ---------------- scoreboard / monitor state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int last_idx[$];
  int beat_cyc[$];
  int rd_cyc[$];
  int rd_addr_q[$];
  int cyc, beats, issued, drained_cnt, busy_cnt, stall_bad, last_bad, max_out;
  int iss_a, iss_b, out_b;
  bit prev_stall;
  logic [31:0] prev_d;
  logic prev_l;

  task automatic clear_mon();
    got_q.delete(); last_idx.delete(); beat_cyc.delete();
    rd_cyc.delete(); rd_addr_q.delete();
    beats = 0; issued = 0; drained_cnt = 0; busy_cnt = 0;
    stall_bad = 0; last_bad = 0; max_out = 0; prev_stall = 0;
    iss_a = -1; iss_b = -2; out_b = -1;
  endtask

  // Reference model: the stream must be the RAM contents in raster order.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(ram[i]);
  endtask

  function automatic int data_errors();
    int n = 0;
    for (int i = 0; i < N; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) n++;
    if (got_q.size() > N) n += got_q.size() - N;
    return n;
  endfunction

  // Called at a negedge: apply ready, observe one cycle, advance to the next negedge.
  task automatic step(input bit rdy);
    m_ready = rdy;
    #1;
    cyc++;
    if (rd_en) begin
      rd_cyc.push_back(cyc);
      rd_addr_q.push_back(int'(rd_addr));
      issued++;
    end
    if (m_last && !m_valid) last_bad++;
    if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stall_bad++;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      if (m_last) last_idx.push_back(beats);
      beat_cyc.push_back(cyc);
      beats++;
    end
    prev_stall = m_valid && !m_ready;
    prev_d = m_data;
    prev_l = m_last;
    if (drained) drained_cnt++;
    if (busy) busy_cnt++;
    if (issued - beats > max_out) max_out = issued - beats;
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode: 0 full ready, 1 alternating, 2 stall 20 cycles at beat 5, 3 random.
  task automatic run_frame(input int mode, input bit toggle_done, input int abort_at);
    int k = 0;
    int stall_left = 0;
    int stall_idx = 0;
    bit stalled_once = 0;
    bit rdy;
    clear_mon();
    done_in = 1'b1;
    while (drained_cnt == 0 && k < 600 && !(abort_at > 0 && beats >= abort_at)) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = k[0];
        3: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      if (mode == 2 && !stalled_once && beats == 5) begin
        stalled_once = 1;
        stall_left = 20;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        stall_idx++;
      end
      if (toggle_done) begin
        if (k == 8) done_in = 1'b0;
        if (k == 10) done_in = 1'b1;
      end
      step(rdy);
      if (mode == 2 && stall_idx == 2 && iss_a < 0) iss_a = issued;
      if (mode == 2 && stall_idx == 20 && out_b < 0) begin
        iss_b = issued;
        out_b = issued - beats;
      end
      k++;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0; done_in = 1'b0; m_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (rd_en !== 1'b0)   begin failures++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== 6'd0) begin failures++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 32'd0) begin failures++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    checks++; if (m_last !== 1'b0)  begin failures++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (drained !== 1'b0) begin failures++; $display("FAIL reset_drained: got %b want 0", drained); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    int bad_addr = 0;
    int bad_gap = 0;
    int t;
    for (int i = 0; i < 64; i++) ram[i] = 32'(3 * i);
    build_exp();
    run_frame(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b1);
    checks++; if (drained_cnt !== 1) begin failures++; $display("FAIL full_drained_pulses: got %0d want 1", drained_cnt); end
    checks++; if (data_errors() !== 0) begin failures++; $display("FAIL full_data: got %0d bad words (size %0d) want 0", data_errors(), got_q.size()); end
    checks++; if (last_idx.size() !== 1 || last_idx[0] !== N - 1) begin failures++; $display("FAIL full_m_last: got %0d last beats want 1 at index %0d", last_idx.size(), N - 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_after: got %b want 0", busy); end
    for (int i = 0; i < N; i++) begin
      if (i >= rd_addr_q.size() || rd_addr_q[i] != i) bad_addr++;
      if (i > 0 && i < rd_cyc.size() && rd_cyc[i] != rd_cyc[i-1] + 1) bad_addr++;
      if (i > 0 && i < beat_cyc.size() && beat_cyc[i] != beat_cyc[i-1] + 1) bad_gap++;
    end
    checks++; if (bad_addr !== 0 || rd_addr_q.size() !== N) begin failures++; $display("FAIL full_rd_addr_seq: got %0d errors (%0d reads) want 0 (%0d reads)", bad_addr, rd_addr_q.size(), N); end
    checks++; if (bad_gap !== 0) begin failures++; $display("FAIL full_beat_gaps: got %0d gaps want 0", bad_gap); end
    t = (rd_cyc.size() > 0) ? rd_cyc[0] : -100;
    checks++; if (beat_cyc.size() == 0 || beat_cyc[0] !== t + 2) begin failures++; $display("FAIL full_first_latency: got cycle %0d want %0d", beat_cyc.size() ? beat_cyc[0] : -1, t + 2); end
    checks++; if (beat_cyc.size() != N || beat_cyc[N-1] !== t + N + 1) begin failures++; $display("FAIL full_last_cycle: got %0d beats want last at cycle %0d", beat_cyc.size(), t + N + 1); end
    checks++; if (last_bad !== 0) begin failures++; $display("FAIL full_last_without_valid: got %0d want 0", last_bad); end
  endtask

  task automatic test_alternate();
    done_in = 1'b0;
    step(1'b1);
    build_exp();
    run_frame(1, 0, 0);
    step(1'b1);
    checks++; if (data_errors() !== 0) begin failures++; $display("FAIL alt_data: got %0d bad words (size %0d) want 0", data_errors(), got_q.size()); end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL alt_stall_stable: got %0d unstable cycles want 0", stall_bad); end
    checks++; if (max_out > 2) begin failures++; $display("FAIL alt_outstanding: got %0d want <=2", max_out); end
    checks++; if (drained_cnt !== 1) begin failures++; $display("FAIL alt_drained: got %0d want 1", drained_cnt); end
  endtask

  task automatic test_stall();
    int bad_gap = 0;
    done_in = 1'b0;
    step(1'b1);
    build_exp();
    run_frame(2, 0, 0);
    step(1'b1);
    checks++; if (data_errors() !== 0) begin failures++; $display("FAIL stall_data: got %0d bad words want 0", data_errors()); end
    checks++; if (got_q.size() < 6 || got_q[5] !== 32'd15) begin failures++; $display("FAIL stall_word5: got size %0d want word 15 at beat 5", got_q.size()); end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
    checks++; if (iss_b !== iss_a) begin failures++; $display("FAIL stall_rd_stops: got %0d reads at end want %0d", iss_b, iss_a); end
    checks++; if (out_b !== 2) begin failures++; $display("FAIL stall_buffered: got %0d outstanding want 2", out_b); end
    for (int i = 6; i < beat_cyc.size(); i++) if (beat_cyc[i] != beat_cyc[i-1] + 1) bad_gap++;
    checks++; if (bad_gap !== 0 || beat_cyc.size() !== N) begin failures++; $display("FAIL stall_resume_gapfree: got %0d gaps (%0d beats) want 0 (%0d beats)", bad_gap, beat_cyc.size(), N); end
  endtask

  task automatic test_held_done_retrigger();
    // done_in is still high from the previous frame.
    clear_mon();
    for (int i = 0; i < 20; i++) step(1'b1);
    checks++; if (issued !== 0 || busy_cnt !== 0) begin failures++; $display("FAIL held_no_restart: got %0d reads %0d busy cycles want 0", issued, busy_cnt); end
    done_in = 1'b0;
    step(1'b1);
    for (int i = 0; i < 64; i++) ram[i] = 32'(i - 18);
    build_exp();
    run_frame(0, 0, 0);
    step(1'b1);
    checks++; if (data_errors() !== 0) begin failures++; $display("FAIL retrig_data: got %0d bad words want 0", data_errors()); end
    checks++; if (got_q.size() == 0 || $signed(got_q[0]) !== -32'sd18) begin failures++; $display("FAIL retrig_first: got size %0d want first word -18", got_q.size()); end
    checks++; if (rd_addr_q.size() == 0 || rd_addr_q[0] !== 0) begin failures++; $display("FAIL retrig_addr0: got %0d reads want first address 0", rd_addr_q.size()); end
  endtask

  task automatic test_reset_midframe();
    done_in = 1'b0;
    step(1'b1);
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    run_frame(0, 0, 10);
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin failures++; $display("FAIL midreset_async: got valid=%b rd_en=%b busy=%b last=%b want all 0", m_valid, rd_en, busy, m_last); end
    done_in = 1'b0;
    @(negedge clk);
    clear_mon();
    for (int i = 0; i < 4; i++) step(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);
    checks++; if (drained_cnt !== 0 || beats !== 0) begin failures++; $display("FAIL midreset_quiet: got %0d drained %0d beats want 0", drained_cnt, beats); end
    build_exp();
    run_frame(3, 0, 0);
    step(1'b1);
    checks++; if (data_errors() !== 0) begin failures++; $display("FAIL midreset_restart_data: got %0d bad words want 0", data_errors()); end
    checks++; if (drained_cnt !== 1) begin failures++; $display("FAIL midreset_restart_drained: got %0d want 1", drained_cnt); end
  endtask

  task automatic test_done_toggle();
    done_in = 1'b0;
    step(1'b1);
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    build_exp();
    run_frame(3, 1, 0);
    for (int i = 0; i < 15; i++) step(1'b1);
    checks++; if (got_q.size() !== N) begin failures++; $display("FAIL toggle_beats: got %0d want %0d", got_q.size(), N); end
    checks++; if (data_errors() !== 0) begin failures++; $display("FAIL toggle_data: got %0d bad words want 0", data_errors()); end
    checks++; if (drained_cnt !== 1) begin failures++; $display("FAIL toggle_drained: got %0d want 1", drained_cnt); end
    checks++; if (issued !== N) begin failures++; $display("FAIL toggle_reads: got %0d want %0d", issued, N); end
  endtask

  initial begin
    cyc = 0;
    clear_mon();
    test_reset();
    test_full_rate();
    test_alternate();
    test_stall();
    test_held_done_retrigger();
    test_reset_midframe();
    test_done_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
